a2d_rr_sequencer: RTL

Round-robin scheduler for the Segway's single shared SPI A2D. Each `nxt` request runs one two-transaction conversion: a channel-select write followed by a result read. Channels are visited in a fixed rotation: left load cell, right load cell, steer pot, battery. Sits between the SPI master (`SPI_mnrch`, external) and the consumers of `lft_ld`/`rght_ld`/`steer_pot`/`batt` (rider-detect, steer_en, balance control).

---
 rtl/segway_pkg.sv | 42 ++++
 rtl/a2d_rr_sequencer_if.sv | 39 +++
 rtl/a2d_tmo_cnt.sv | 35 +++
 rtl/a2d_rr_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// ---------------------------------------------------------------------------
// segway_pkg
// Shared types and constants for the Segway A2D round-robin sequencer.
//   a2d_state_t   : sequencer FSM states
//   CH_*          : A2D channel numbers for each rotation slot
//   A2D_TIMEOUT   : default cycles allowed between wrt and done
//   rr_to_chnl()  : rotation index -> A2D channel
//   chnl_cmd()    : A2D channel -> 16-bit SPI command word
// ---------------------------------------------------------------------------
package segway_pkg;

  localparam int unsigned A2D_TIMEOUT = 1024;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,  // waiting for nxt or a pending request
    ST_CNV,   // channel-select transaction in flight
    ST_GAP,   // one cycle of dead time between transactions
    ST_RD,    // result-read transaction in flight
    ST_CAP    // commit captured result to its register
  } a2d_state_t;

  function automatic logic [2:0] rr_to_chnl(input logic [1:0] rr);
    logic [2:0] chnl;
    case (rr)
      2'd0:    chnl = CH_LFT;
      2'd1:    chnl = CH_RGHT;
      2'd2:    chnl = CH_STEER;
      default: chnl = CH_BATT;
    endcase
    return chnl;
  endfunction

  function automatic logic [15:0] chnl_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_rr_sequencer_if.sv
// ---------------------------------------------------------------------------
// a2d_rr_sequencer_if
// Bundles the sequencer's request, SPI-master and result-consumer signals.
//   nxt                      : conversion request (into sequencer)
//   wrt / cmd                : SPI transaction start and command word (out)
//   done / resp              : SPI completion pulse and read data (in)
//   lft_ld/rght_ld/steer_pot/batt : latest 12-bit results (out)
//   upd / upd_sel            : result-written pulse and rotation index (out)
//   overrun / tmo_err        : sticky error flags (out)
// modport master : the sequencer itself
// modport slave  : the environment (SPI master, requester, consumers)
// ---------------------------------------------------------------------------
interface a2d_rr_sequencer_if;
  logic        nxt;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        upd;
  logic [1:0]  upd_sel;
  logic        overrun;
  logic        tmo_err;

  modport master (
    input  nxt, done, resp,
    output wrt, cmd, lft_ld, rght_ld, steer_pot, batt,
           upd, upd_sel, overrun, tmo_err
  );

  modport slave (
    output nxt, done, resp,
    input  wrt, cmd, lft_ld, rght_ld, steer_pot, batt,
           upd, upd_sel, overrun, tmo_err
  );
endinterface

// File: rtl/a2d_tmo_cnt.sv
// ---------------------------------------------------------------------------
// a2d_tmo_cnt
// Clearable saturating cycle counter used as the SPI transaction watchdog.
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   i_clr  : restart counting from zero (asserted with each wrt launch)
//   o_hit  : high while the count has reached TIMEOUT
// ---------------------------------------------------------------------------
module a2d_tmo_cnt #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_hit
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_hit = (r_cnt == LIMIT);

endmodule

// File: rtl/a2d_rr_sequencer.sv
// ---------------------------------------------------------------------------
// a2d_rr_sequencer
// Round-robin scheduler for the single shared SPI A2D. Each nxt request runs
// a channel-select write followed by a result read, visiting channels in the
// order lft (ch0), rght (ch4), steer (ch5), batt (ch6).
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset (aborts any transaction)
//   io_a2d : master modport of a2d_rr_sequencer_if (request, SPI, results)
//   TIMEOUT: cycles allowed between wrt and done before abandoning
// All outputs are registered.
// ---------------------------------------------------------------------------
module a2d_rr_sequencer
  import segway_pkg::*;
#(
  parameter int unsigned TIMEOUT = A2D_TIMEOUT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  a2d_rr_sequencer_if.master io_a2d
);

  a2d_state_t  r_state;
  a2d_state_t  w_state_nxt;

  logic [1:0]  r_rr;
  logic        r_pend;
  logic        r_wrt;
  logic [15:0] r_cmd;
  logic        r_upd;
  logic [1:0]  r_upd_sel;
  logic        r_overrun;
  logic        r_tmo_err;
  logic [11:0] r_cap;
  logic [11:0] r_lft;
  logic [11:0] r_rght;
  logic [11:0] r_steer;
  logic [11:0] r_batt;

  logic        w_start;
  logic        w_hit;
  logic        w_wrt_nxt;
  logic        w_upd_nxt;
  logic [15:0] w_cmd_nxt;
  logic        w_pend_nxt;
  logic        w_ovr_set;
  logic        w_tmo_set;
  logic        w_rr_adv;
  logic        w_cap_en;
  logic        w_unused_resp_hi;

  // resp[15:12] carries no result bits and is deliberately discarded.
  assign w_unused_resp_hi = ^io_a2d.resp[15:12];

  assign w_start = (r_state == ST_IDLE) && (io_a2d.nxt || r_pend);

  // Cleared on the same edge wrt rises, so the count is 0 in the wrt cycle
  // and a stale saturated count can never fire on a fresh transaction.
  a2d_tmo_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_wrt_nxt),
    .o_hit (w_hit)
  );

  // ---- FSM: state register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- FSM: next-state logic ----
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_CNV;
      ST_CNV: begin
        if (io_a2d.done)  w_state_nxt = ST_GAP;
        else if (w_hit)   w_state_nxt = ST_IDLE;
      end
      ST_GAP:  w_state_nxt = ST_RD;
      ST_RD: begin
        if (io_a2d.done)  w_state_nxt = ST_CAP;
        else if (w_hit)   w_state_nxt = ST_IDLE;
      end
      ST_CAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- FSM: output / control decode (next values of registered outputs) ----
  always_comb begin
    w_wrt_nxt  = 1'b0;
    w_upd_nxt  = 1'b0;
    w_cmd_nxt  = r_cmd;
    w_cap_en   = 1'b0;
    w_tmo_set  = 1'b0;
    w_rr_adv   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_wrt_nxt = 1'b1;
          w_cmd_nxt = chnl_cmd(rr_to_chnl(r_rr));
        end else begin
          w_cmd_nxt = '0;
        end
      end
      ST_CNV: begin
        if (!io_a2d.done && w_hit) begin
          w_tmo_set = 1'b1;
          w_rr_adv  = 1'b1;
        end
      end
      ST_GAP:  w_wrt_nxt = 1'b1;  // read reuses the held channel cmd
      ST_RD: begin
        if (io_a2d.done) begin
          w_cap_en = 1'b1;
        end else if (w_hit) begin
          w_tmo_set = 1'b1;
          w_rr_adv  = 1'b1;
        end
      end
      ST_CAP: begin
        w_upd_nxt = 1'b1;
        w_rr_adv  = 1'b1;
      end
      default: ;
    endcase
  end

  // Single-entry request buffer. Starting a conversion consumes at most one
  // request; a second outstanding request is dropped and flagged.
  always_comb begin
    w_pend_nxt = r_pend;
    w_ovr_set  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_start) w_pend_nxt = 1'b0;
      if (io_a2d.nxt && r_pend) w_ovr_set = 1'b1;
    end else if (io_a2d.nxt) begin
      if (!r_pend) w_pend_nxt = 1'b1;
      else         w_ovr_set  = 1'b1;
    end
  end

  // ---- Datapath / output registers ----
  // NOTE: result registers are reset along with control because consumers
  // (rider detect, balance) read them straight out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr      <= 2'd0;
      r_pend    <= 1'b0;
      r_wrt     <= 1'b0;
      r_cmd     <= '0;
      r_upd     <= 1'b0;
      r_upd_sel <= 2'd0;
      r_overrun <= 1'b0;
      r_tmo_err <= 1'b0;
      r_cap     <= '0;
      r_lft     <= '0;
      r_rght    <= '0;
      r_steer   <= '0;
      r_batt    <= '0;
    end else begin
      r_wrt  <= w_wrt_nxt;
      r_upd  <= w_upd_nxt;
      r_cmd  <= w_cmd_nxt;
      r_pend <= w_pend_nxt;
      if (w_ovr_set) r_overrun <= 1'b1;
      if (w_tmo_set) r_tmo_err <= 1'b1;
      if (w_rr_adv)  r_rr      <= r_rr + 2'd1;  // wraps 3 -> 0
      if (w_cap_en)  r_cap     <= io_a2d.resp[11:0];
      if (w_upd_nxt) begin
        r_upd_sel <= r_rr;
        case (r_rr)
          2'd0:    r_lft   <= r_cap;
          2'd1:    r_rght  <= r_cap;
          2'd2:    r_steer <= r_cap;
          default: r_batt  <= r_cap;
        endcase
      end
    end
  end

  assign io_a2d.wrt       = r_wrt;
  assign io_a2d.cmd       = r_cmd;
  assign io_a2d.upd       = r_upd;
  assign io_a2d.upd_sel   = r_upd_sel;
  assign io_a2d.overrun   = r_overrun;
  assign io_a2d.tmo_err   = r_tmo_err;
  assign io_a2d.lft_ld    = r_lft;
  assign io_a2d.rght_ld   = r_rght;
  assign io_a2d.steer_pot = r_steer;
  assign io_a2d.batt      = r_batt;

endmodule
